// File: rtl/data_memory_lsu_if.sv
// rtl/data_memory_lsu_if.sv - request/response bus between the MEM stage and the data memory
interface data_memory_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_lsu.sv
// rtl/data_memory_lsu.sv - byte-addressable RV32I data memory with wait states and fault reporting
module data_memory_lsu #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  data_memory_lsu_if.slave   bus
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAST     = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam bit          HAS_WAIT = (LATENCY > 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         lane_q, lane_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [31:0]        mem [DEPTH_WORDS];

  logic [31:0]        in_off;
  logic               in_err;
  logic               use_live;
  logic               c_we;
  logic [2:0]         c_f3;
  logic [1:0]         c_lane;
  logic [IDX_W-1:0]   c_idx;
  logic [31:0]        c_wdata;
  logic               c_err;
  logic               commit;
  logic [31:0]        rd_word;
  logic [31:0]        rd_shift;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        load_val;
  logic [3:0]         st_be;
  logic [31:0]        st_data;
  logic               wr_en;

  // Classify the incoming request: any fault collapses to one error bit.
  always_comb begin
    in_off = bus.req_addr - BASE_ADDR;
    in_err = 1'b0;
    if ({1'b0, in_off} >= LIMIT) begin
      in_err = 1'b1;
    end else if (bus.req_funct3[1:0] == 2'b11 ||
                 (bus.req_funct3[2] && (bus.req_we || bus.req_funct3[1]))) begin
      in_err = 1'b1;
    end else if (bus.req_funct3[1:0] == 2'b01 && in_off[0]) begin
      in_err = 1'b1;
    end else if (bus.req_funct3[1:0] == 2'b10 && in_off[1:0] != 2'b00) begin
      in_err = 1'b1;
    end
  end

  // With zero wait states the commit edge is the acceptance edge, so it works from the live request.
  always_comb begin
    use_live = (state_q == IDLE);
    c_we     = use_live ? bus.req_we         : we_q;
    c_f3     = use_live ? bus.req_funct3     : f3_q;
    c_lane   = use_live ? in_off[1:0]        : lane_q;
    c_idx    = use_live ? in_off[IDX_W+1:2]  : idx_q;
    c_wdata  = use_live ? bus.req_wdata      : wdata_q;
    c_err    = use_live ? in_err             : err_q;
  end

  // Pick the addressed byte or half and extend it according to funct3.
  always_comb begin
    rd_word  = mem[c_idx];
    rd_shift = rd_word >> {c_lane, 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = c_lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (c_f3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'h0, rd_byte};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = 32'h0;
    endcase
  end

  // Replicate store data across lanes and enable only the lanes being written.
  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'h0;
    case (c_f3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << c_lane;
        st_data = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = c_lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{c_wdata[15:0]}};
      end
      2'b10: begin
        st_be   = 4'b1111;
        st_data = c_wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  // Sequence IDLE -> (WAIT) -> RESP and capture the response on the edge entering RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    f3_d      = f3_q;
    lane_d    = lane_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          lane_d  = in_off[1:0];
          idx_d   = in_off[IDX_W+1:2];
          wdata_d = bus.req_wdata;
          err_d   = in_err;
          cnt_d   = 4'd0;
          state_d = HAS_WAIT ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == LAST) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    commit = (state_d == RESP) && (state_q != RESP);
    if (commit) begin
      rsp_err_d = c_err;
      rdata_d   = (c_err || c_we) ? 32'h0 : load_val;
    end
  end

  // A commit while reset is asserted must never reach the array.
  assign wr_en = commit && c_we && !c_err && rst_n;

  // Control and response registers; memory contents are deliberately left out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      lane_q    <= 2'b00;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      lane_q    <= lane_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Byte-lane masked write into the storage array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[c_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb/tb_data_memory_lsu.sv - randomized and directed checks of data_memory_lsu against a byte-level model
module tb_data_memory_lsu;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic        vld [3];
  logic        we  [3];
  logic [31:0] addr[3];
  logic [2:0]  f3  [3];
  logic [31:0] wd  [3];
  logic        rdy [3];
  logic        rvld[3];
  logic [31:0] rrd [3];
  logic        rerr[3];

  data_memory_lsu_if b0 ();
  data_memory_lsu_if b1 ();
  data_memory_lsu_if b2 ();

  assign b0.req_valid = vld[0]; assign b0.req_we = we[0]; assign b0.req_addr = addr[0];
  assign b0.req_funct3 = f3[0]; assign b0.req_wdata = wd[0];
  assign rdy[0] = b0.req_ready; assign rvld[0] = b0.rsp_valid; assign rrd[0] = b0.rsp_rdata;
  assign rerr[0] = b0.rsp_err;
  assign b1.req_valid = vld[1]; assign b1.req_we = we[1]; assign b1.req_addr = addr[1];
  assign b1.req_funct3 = f3[1]; assign b1.req_wdata = wd[1];
  assign rdy[1] = b1.req_ready; assign rvld[1] = b1.rsp_valid; assign rrd[1] = b1.rsp_rdata;
  assign rerr[1] = b1.rsp_err;
  assign b2.req_valid = vld[2]; assign b2.req_we = we[2]; assign b2.req_addr = addr[2];
  assign b2.req_funct3 = f3[2]; assign b2.req_wdata = wd[2];
  assign rdy[2] = b2.req_ready; assign rvld[2] = b2.rsp_valid; assign rrd[2] = b2.rsp_rdata;
  assign rerr[2] = b2.rsp_err;

  data_memory_lsu #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(0))
    u_lat0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  data_memory_lsu #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .LATENCY(0))
    u_base (.clk(clk), .rst_n(rst_n), .bus(b1));
  data_memory_lsu #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(3))
    u_lat3 (.clk(clk), .rst_n(rst2_n), .bus(b2));

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [2:0]  f;
    logic [31:0] d;
    logic [31:0] xr;
    logic        xe;
  } op_t;

  logic [7:0] mdl [int unsigned];

  function automatic logic [31:0] base_of(input int i);
    return (i == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  function automatic void model(input int i, input logic w, input logic [31:0] a,
                                input logic [2:0] f, input logic [31:0] d,
                                output logic [31:0] rd, output logic er);
    logic [31:0] off;
    int unsigned key;
    int nb;
    logic legal;
    off   = a - base_of(i);
    nb    = 1 << f[1:0];
    legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    rd    = 32'h0;
    er    = 1'b0;
    if (off >= 32'd4096) er = 1'b1;
    else if (!legal) er = 1'b1;
    else if ((off % nb) != 0) er = 1'b1;
    if (!er) begin
      key = i * 32'h10000 + off;
      if (w) begin
        for (int k = 0; k < nb; k++) mdl[key + k] = d[8*k +: 8];
      end else begin
        for (int k = 0; k < nb; k++) rd = rd | (32'(mdl[key + k]) << (8 * k));
        if (!f[2] && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8 * nb));
      end
    end
  endfunction

  task automatic access(input int i, input logic w, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat, output int busy);
    int n;
    @(negedge clk);
    vld[i] = 1'b1; we[i] = w; addr[i] = a; f3[i] = f; wd[i] = d;
    n = 0;
    while (!rdy[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    vld[i] = 1'b0;
    lat = -1; busy = 0; rd = 'x; er = 1'bx;
    for (n = 1; n <= 40; n++) begin
      if (rdy[i] && lat != -1) break;
      if (!rdy[i]) busy++;
      if (rvld[i]) begin
        if (lat == -1) begin
          lat = n; rd = rrd[i]; er = rerr[i];
        end else begin
          lat = -2;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (rvld[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold[%0d] rsp_valid=%b expected 0", i, rvld[i]);
      end
    end
    rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({rdy[i], rvld[i], rerr[i], rrd[i]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL reset_state[%0d] ready=%b valid=%b err=%b rdata=%h expected 1 0 0 00000000",
                 i, rdy[i], rvld[i], rerr[i], rrd[i]);
      end
    end
  endtask

  task automatic test_lanes();
    op_t tbl [15] = '{
      '{1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0},
      '{1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0},
      '{1'b1, 32'h11, 3'b000, 32'hFFFFFF5A, 32'h0,        1'b0},
      '{1'b0, 32'h10, 3'b010, 32'h0,        32'hDEAD5AEF, 1'b0},
      '{1'b0, 32'h11, 3'b000, 32'h0,        32'h0000005A, 1'b0},
      '{1'b1, 32'h12, 3'b001, 32'h12348001, 32'h0,        1'b0},
      '{1'b0, 32'h12, 3'b001, 32'h0,        32'hFFFF8001, 1'b0},
      '{1'b0, 32'h12, 3'b101, 32'h0,        32'h00008001, 1'b0},
      '{1'b0, 32'h13, 3'b010, 32'h0,        32'h0,        1'b1},
      '{1'b1, 32'h11, 3'b001, 32'h0000FFFF, 32'h0,        1'b1},
      '{1'b0, 32'h10, 3'b011, 32'h0,        32'h0,        1'b1},
      '{1'b1, 32'h10, 3'b100, 32'h0,        32'h0,        1'b1},
      '{1'b0, 32'h10, 3'b010, 32'h0,        32'h80015AEF, 1'b0},
      '{1'b0, 32'h13, 3'b100, 32'h0,        32'h00000080, 1'b0},
      '{1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0}
    };
    logic [31:0] rd, mr;
    logic er, me;
    int lat, busy;
    for (int k = 0; k < 15; k++) begin
      model(0, tbl[k].w, tbl[k].a, tbl[k].f, tbl[k].d, mr, me);
      access(0, tbl[k].w, tbl[k].a, tbl[k].f, tbl[k].d, rd, er, lat, busy);
      n_chk++;
      if ({rd, er} !== {tbl[k].xr, tbl[k].xe}) begin
        n_fail++;
        $display("FAIL lanes_rsp[%0d] rdata=%h err=%b expected %h %b", k, rd, er, tbl[k].xr, tbl[k].xe);
      end
      n_chk++;
      if ({lat, busy} !== {32'sd1, 32'sd1}) begin
        n_fail++; $display("FAIL lanes_timing[%0d] latency=%0d busy=%0d expected 1 1", k, lat, busy);
      end
    end
  endtask

  task automatic test_range();
    op_t tbl [7] = '{
      '{1'b1, 32'h1000, 3'b010, 32'hCAFEF00D, 32'h0,        1'b0},
      '{1'b1, 32'h1FFC, 3'b010, 32'h12345678, 32'h0,        1'b0},
      '{1'b1, 32'h0FFC, 3'b010, 32'hBAD0BAD0, 32'h0,        1'b1},
      '{1'b1, 32'h2000, 3'b010, 32'hBAD0BAD0, 32'h0,        1'b1},
      '{1'b0, 32'h1FFC, 3'b010, 32'h0,        32'h12345678, 1'b0},
      '{1'b0, 32'h1000, 3'b010, 32'h0,        32'hCAFEF00D, 1'b0},
      '{1'b0, 32'h0000, 3'b000, 32'h0,        32'h0,        1'b1}
    };
    logic [31:0] rd, mr;
    logic er, me;
    int lat, busy;
    for (int k = 0; k < 7; k++) begin
      model(1, tbl[k].w, tbl[k].a, tbl[k].f, tbl[k].d, mr, me);
      access(1, tbl[k].w, tbl[k].a, tbl[k].f, tbl[k].d, rd, er, lat, busy);
      n_chk++;
      if ({rd, er} !== {tbl[k].xr, tbl[k].xe}) begin
        n_fail++;
        $display("FAIL range_rsp[%0d] rdata=%h err=%b expected %h %b", k, rd, er, tbl[k].xr, tbl[k].xe);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, xr, a, d;
    logic er, xe, w;
    logic [2:0] f;
    int lat, busy;
    for (int k = 0; k < 16; k++) begin
      a = 32'h40 + 32'(4 * k);
      d = $urandom;
      model(0, 1'b1, a, 3'b010, d, xr, xe);
      access(0, 1'b1, a, 3'b010, d, rd, er, lat, busy);
      n_chk++;
      if ({rd, er} !== {xr, xe}) begin
        n_fail++; $display("FAIL preload[%0d] rdata=%h err=%b expected %h %b", k, rd, er, xr, xe);
      end
    end
    for (int k = 0; k < 60; k++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f = w ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + 32'($urandom_range(0, 255));
        1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = 32'h40 + 32'($urandom_range(0, 63));
      endcase
      d = $urandom;
      model(0, w, a, f, d, xr, xe);
      access(0, w, a, f, d, rd, er, lat, busy);
      n_chk++;
      if ({rd, er} !== {xr, xe}) begin
        n_fail++;
        $display("FAIL random_rsp[%0d] we=%b addr=%h f3=%b rdata=%h err=%b expected %h %b",
                 k, w, a, f, rd, er, xr, xe);
      end
      n_chk++;
      if (lat !== 1) begin
        n_fail++; $display("FAIL random_latency[%0d] latency=%0d expected 1", k, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        ow [8];
    logic [31:0] oa [8];
    logic [31:0] od [8];
    logic [31:0] xr [8];
    logic        xe [8];
    int acc_c[$];
    int rsp_c[$];
    logic [31:0] got_rd[$];
    logic got_er[$];
    int k, m;
    logic adv;
    for (int j = 0; j < 8; j++) begin
      ow[j] = (j < 4);
      oa[j] = 32'h80 + 32'(4 * (j % 4));
      od[j] = ow[j] ? $urandom : 32'h0;
      model(2, ow[j], oa[j], 3'b010, od[j], xr[j], xe[j]);
    end
    @(negedge clk);
    k = 0; adv = 1'b0;
    vld[2] = 1'b1; we[2] = ow[0]; addr[2] = oa[0]; f3[2] = 3'b010; wd[2] = od[0];
    for (int c = 0; c < 80; c++) begin
      if (rvld[2]) begin
        rsp_c.push_back(c); got_rd.push_back(rrd[2]); got_er.push_back(rerr[2]);
      end
      if (vld[2] && rdy[2]) begin
        acc_c.push_back(c); k++; adv = 1'b1;
      end
      @(negedge clk);
      if (adv) begin
        adv = 1'b0;
        if (k < 8) begin
          we[2] = ow[k]; addr[2] = oa[k]; wd[2] = od[k];
        end else begin
          vld[2] = 1'b0;
        end
      end
    end
    vld[2] = 1'b0;
    n_chk++;
    if ({acc_c.size(), rsp_c.size()} !== {32'sd8, 32'sd8}) begin
      n_fail++;
      $display("FAIL b2b_count accepts=%0d responses=%0d expected 8 8", acc_c.size(), rsp_c.size());
    end
    m = (acc_c.size() < rsp_c.size()) ? acc_c.size() : rsp_c.size();
    if (m > 8) m = 8;
    for (int j = 0; j < m; j++) begin
      n_chk++;
      if (rsp_c[j] - acc_c[j] !== 4) begin
        n_fail++; $display("FAIL b2b_latency[%0d] cycles=%0d expected 4", j, rsp_c[j] - acc_c[j]);
      end
      if (j > 0) begin
        n_chk++;
        if (acc_c[j] - acc_c[j-1] !== 5) begin
          n_fail++; $display("FAIL b2b_spacing[%0d] cycles=%0d expected 5", j, acc_c[j] - acc_c[j-1]);
        end
      end
      n_chk++;
      if ({got_rd[j], got_er[j]} !== {xr[j], xe[j]}) begin
        n_fail++;
        $display("FAIL b2b_rsp[%0d] rdata=%h err=%b expected %h %b", j, got_rd[j], got_er[j], xr[j], xe[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, xr;
    logic er, xe;
    int lat, busy, seen;
    model(2, 1'b1, 32'h20, 3'b010, 32'h11111111, xr, xe);
    access(2, 1'b1, 32'h20, 3'b010, 32'h11111111, rd, er, lat, busy);
    access(2, 1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat, busy);
    n_chk++;
    if ({rd, er, lat, busy} !== {32'h11111111, 1'b0, 32'sd4, 32'sd4}) begin
      n_fail++;
      $display("FAIL pre_reset_load rdata=%h err=%b latency=%0d busy=%0d expected 11111111 0 4 4",
               rd, er, lat, busy);
    end
    @(negedge clk);
    vld[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; f3[2] = 3'b010; wd[2] = 32'h0000AAAA;
    @(posedge clk);
    @(negedge clk);
    vld[2] = 1'b0;
    @(negedge clk);
    rst2_n = 1'b0;
    #1;
    n_chk++;
    if ({rvld[2], rerr[2], rrd[2]} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_clear valid=%b err=%b rdata=%h expected 0 0 00000000", rvld[2], rerr[2], rrd[2]);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rvld[2]) seen++;
    end
    rst2_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rvld[2]) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_mid_no_rsp pulses=%0d expected 0", seen);
    end
    access(2, 1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat, busy);
    n_chk++;
    if ({rd, er} !== {32'h11111111, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid_discard rdata=%h err=%b expected 11111111 0", rd, er);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; f3[i] = 3'b000; wd[i] = 32'h0;
    end
    test_reset();
    test_lanes();
    test_range();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
